// File: rtl/aes_pkg.sv
// Shared AES widths, engine FSM encoding and GF(2^8) helpers.
// Used by the S-box lanes and the SubBytes engine.
package aes_pkg;

    localparam int AES_STATE_W   = 128;
    localparam int AES_BYTE_W    = 8;
    localparam int AES_NUM_BYTES = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sub_fsm_e;

    // Byte 0 is the most significant byte of the state.
    function automatic logic [AES_BYTE_W-1:0] get_byte(input logic [AES_STATE_W-1:0] s,
                                                       input int i);
        return s[AES_STATE_W-1-AES_BYTE_W*i -: AES_BYTE_W];
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        logic       hi;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa = aa ^ 8'h1b;
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // a^254 == a^-1 for a != 0, and maps 0 to 0 as SubBytes requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h01;
        t = a;
        for (int k = 1; k < 8; k++) begin
            t = gf_mul(t, t);
            p = gf_mul(p, t);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// One combinational AES S-box lane: GF(2^8) inversion plus affine map; INV_SBOX_EN adds the inverse path.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the engine holds the lane inputs stable for a whole cycle.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
`ifdef INV_SBOX_EN
    input  logic       fwd_en,
`endif
    output logic [7:0] dout
);

    logic [7:0] inv_in;
    logic [7:0] inv_out;
    logic [7:0] fwd_out;

    always_comb begin
`ifdef INV_SBOX_EN
        // Inverse direction undoes the affine map before inverting.
        inv_in = fwd_en ? din
                        : (rotl8(din, 1) ^ rotl8(din, 3) ^ rotl8(din, 6) ^ 8'h05);
`else
        inv_in = din;
`endif
        inv_out = gf_inv(inv_in);
        fwd_out = inv_out ^ rotl8(inv_out, 1) ^ rotl8(inv_out, 2)
                ^ rotl8(inv_out, 3) ^ rotl8(inv_out, 4) ^ 8'h63;
`ifdef INV_SBOX_EN
        dout = fwd_en ? fwd_out : inv_out;
`else
        dout = fwd_out;
`endif
    end

endmodule

// File: rtl/sub_bytes_engine.sv
// AES SubBytes/InvSubBytes over a 128-bit state, BYTES_PER_CYCLE bytes per cycle (INV_SBOX_EN enables decrypt).
// Latency: sub_ready_out pulses in the cycle after accept edge + 16/BYTES_PER_CYCLE.
// Backpressure: none; starts while busy are dropped, a start in the ready cycle is accepted.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sub_start_in,
    input  logic                   en_de,
    input  logic [AES_STATE_W-1:0] state_in,
    output logic [AES_STATE_W-1:0] state_out,
    output logic                   sub_ready_out,
    output logic                   busy
);

    localparam int N     = AES_NUM_BYTES / BYTES_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    sub_fsm_e               fsm_q, fsm_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [AES_STATE_W-1:0] work_q, work_d;
    logic [AES_STATE_W-1:0] state_out_q, state_out_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
`ifdef INV_SBOX_EN
    logic                   mode_q, mode_d;
`else
    logic                   unused_en_de;
    assign unused_en_de = en_de;
`endif

    logic [AES_BYTE_W-1:0] lane_in  [BYTES_PER_CYCLE];
    logic [AES_BYTE_W-1:0] lane_out [BYTES_PER_CYCLE];

    always_comb begin
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            lane_in[j] = get_byte(work_q, int'(cnt_q) * BYTES_PER_CYCLE + j);
        end
    end

    for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
        aes_sbox u_sbox (
            .din    (lane_in[j]),
`ifdef INV_SBOX_EN
            .fwd_en (mode_q),
`endif
            .dout   (lane_out[j])
        );
    end

    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        state_out_d = state_out_q;
        ready_d     = 1'b0;
        busy_d      = busy_q;
`ifdef INV_SBOX_EN
        mode_d      = mode_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (sub_start_in) begin
                    fsm_d  = BUSY;
                    work_d = state_in;
                    cnt_d  = '0;
                    busy_d = 1'b1;
`ifdef INV_SBOX_EN
                    mode_d = en_de;
`endif
                end
            end
            BUSY: begin
                for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
                    work_d[AES_STATE_W-1-AES_BYTE_W*(int'(cnt_q)*BYTES_PER_CYCLE+j) -: AES_BYTE_W]
                        = lane_out[j];
                end
                if (cnt_q == CNT_LAST) begin
                    // Publish the fully substituted state, including this cycle's chunk.
                    fsm_d       = IDLE;
                    cnt_d       = '0;
                    state_out_d = work_d;
                    ready_d     = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            state_out_q <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
`ifdef INV_SBOX_EN
            mode_q      <= 1'b1;
`endif
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            state_out_q <= state_out_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
`ifdef INV_SBOX_EN
            mode_q      <= mode_d;
`endif
        end
    end

    assign state_out     = state_out_q;
    assign sub_ready_out = ready_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine at BYTES_PER_CYCLE = 1, 4 and 16 (N = 16, 4, 1).
// Expected decrypt result depends on INV_SBOX_EN.
module tb_sub_bytes_engine;

    localparam logic [127:0] E_IN   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] E_OUT  = 128'h638293c31bfc33f5c4eeacea4bc12816;
`ifdef INV_SBOX_EN
    localparam logic [127:0] D_OUT  = 128'h00112233445566778899aabbccddeeff;
`else
    localparam logic [127:0] D_OUT  = 128'hfb13dc2eafb0c3e61c289187b3783447;
`endif
    localparam logic [127:0] Z_OUT  = {16{8'h63}};
    localparam logic [127:0] F_OUT  = {16{8'h16}};

    logic         clk;
    logic         rst_n;
    logic         start [3];
    logic         en    [3];
    logic [127:0] sin   [3];
    logic [127:0] sout  [3];
    logic         rdy   [3];
    logic         bsy   [3];
    int           nn    [3] = '{16, 4, 1};

    int n_chk  = 0;
    int n_pass = 0;

    sub_bytes_engine #(.BYTES_PER_CYCLE(1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .sub_start_in(start[0]), .en_de(en[0]),
        .state_in(sin[0]), .state_out(sout[0]), .sub_ready_out(rdy[0]), .busy(bsy[0]));
    sub_bytes_engine #(.BYTES_PER_CYCLE(4)) u_b4 (
        .clk(clk), .rst_n(rst_n), .sub_start_in(start[1]), .en_de(en[1]),
        .state_in(sin[1]), .state_out(sout[1]), .sub_ready_out(rdy[1]), .busy(bsy[1]));
    sub_bytes_engine #(.BYTES_PER_CYCLE(16)) u_b16 (
        .clk(clk), .rst_n(rst_n), .sub_start_in(start[2]), .en_de(en[2]),
        .state_in(sin[2]), .state_out(sout[2]), .sub_ready_out(rdy[2]), .busy(bsy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation on lane-set i; optionally a conflicting start right after accept.
    task automatic run_op(input int i, input logic [127:0] data, input logic e,
                          input logic [127:0] exp, input string tag, input bit extra);
        int first;
        int pulses;
        first  = -1;
        pulses = 0;
        sin[i]   = data;
        en[i]    = e;
        start[i] = 1'b1;
        step();
        chk($sformatf("%s_busy", tag), 128'(bsy[i]), 128'd1);
        start[i] = extra;
        sin[i]   = ~data;
        en[i]    = ~e;
        for (int c = 1; c <= 2 * nn[i] + 4; c++) begin
            step();
            start[i] = 1'b0;
            if (rdy[i]) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    chk($sformatf("%s_dat", tag), sout[i], exp);
                end
            end
        end
        chk($sformatf("%s_lat", tag), 128'(first), 128'(nn[i]));
        chk($sformatf("%s_pulses", tag), 128'(pulses), 128'd1);
        chk($sformatf("%s_hold", tag), sout[i], exp);
        chk($sformatf("%s_idle", tag), 128'(bsy[i]), 128'd0);
    endtask

    task automatic b2b(input int i);
        int first;
        first = -1;
        sin[i]   = {16{8'h00}};
        en[i]    = 1'b1;
        start[i] = 1'b1;
        step();
        start[i] = 1'b0;
        for (int c = 1; c <= 2 * nn[i] + 4 && first < 0; c++) begin
            step();
            if (rdy[i]) first = c;
        end
        chk($sformatf("b2b%0d_lat1", i), 128'(first), 128'(nn[i]));
        chk($sformatf("b2b%0d_dat1", i), sout[i], Z_OUT);
        sin[i]   = {16{8'hff}};
        start[i] = 1'b1;
        step();
        start[i] = 1'b0;
        chk($sformatf("b2b%0d_busy2", i), 128'(bsy[i]), 128'd1);
        first = -1;
        for (int c = 1; c <= 2 * nn[i] + 4 && first < 0; c++) begin
            step();
            if (rdy[i]) first = c;
        end
        chk($sformatf("b2b%0d_lat2", i), 128'(first), 128'(nn[i]));
        chk($sformatf("b2b%0d_dat2", i), sout[i], F_OUT);
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            en[i]    = 1'b1;
            sin[i]   = '0;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst%0d_out", i), sout[i], 128'd0);
            chk($sformatf("rst%0d_rdy", i), 128'(rdy[i]), 128'd0);
            chk($sformatf("rst%0d_busy", i), 128'(bsy[i]), 128'd0);
        end
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 3; i++) begin
            run_op(i, E_IN, 1'b1, E_OUT, $sformatf("enc%0d", i), 1'b0);
            run_op(i, E_OUT, 1'b0, D_OUT, $sformatf("dec%0d", i), 1'b0);
            run_op(i, {16{8'h00}}, 1'b1, Z_OUT, $sformatf("zero%0d", i), 1'b0);
            run_op(i, {16{8'hff}}, 1'b1, F_OUT, $sformatf("ones%0d", i), 1'b0);
            run_op(i, E_IN, 1'b1, E_OUT, $sformatf("busy_start%0d", i), 1'b1);
            b2b(i);
        end

        // Abort mid-operation on the slowest instance; state_out holds 0x16.. beforehand.
        sin[0]   = E_IN;
        en[0]    = 1'b1;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 128'(bsy[0]), 128'd0);
        chk("abort_out", sout[0], 128'd0);
        chk("abort_rdy", 128'(rdy[0]), 128'd0);
        step();
        rst_n  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 24; c++) begin
            step();
            if (rdy[0]) pulses++;
        end
        chk("abort_no_pulse", 128'(pulses), 128'd0);
        chk("abort_idle", 128'(bsy[0]), 128'd0);
        chk("abort_out_hold", sout[0], 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
